// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_pkg;

    // Loader states, from arming through the verdict on the image.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_LOAD,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } loader_state_t;

    // Length header is a little-endian byte pair.
    localparam int unsigned HDR_BYTES = 2;

    // Checksum is a single XOR byte over the payload.
    localparam int unsigned CHK_W = 8;

endpackage

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a length/payload/XOR-checksum byte stream, writes the
// payload into instruction memory and releases the core once the image verifies.
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = CHK_W
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic                       i_in_valid,
    input  logic [WIDTH-1:0]           i_in_data,
    output logic                       o_in_ready,
    output logic                       o_mem_we,
    output logic [$clog2(DEPTH)-1:0]   o_mem_addr,
    output logic [WIDTH-1:0]           o_mem_wdata,
    output logic                       o_cpu_hold,
    output logic                       o_done,
    output logic                       o_err
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned LEN_W = HDR_BYTES * WIDTH;

    loader_state_t    r_state;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    r_len;
    logic [WIDTH-1:0] r_len_lo;
    logic [WIDTH-1:0] r_xor;
    logic             r_in_ready;
    logic             r_mem_we;
    logic [AW-1:0]    r_mem_addr;
    logic [WIDTH-1:0] r_mem_wdata;
    logic             r_cpu_hold;
    logic             r_done;
    logic             r_err;

    logic             w_accept;
    logic [LEN_W-1:0] w_len;
    logic [CW-1:0]    w_cnt_nxt;

    // Handshake, assembled frame length and the post-write byte count.
    assign w_accept  = i_in_valid && r_in_ready;
    assign w_len     = {i_in_data, r_len_lo};
    assign w_cnt_nxt = r_cnt + CW'(1);

    assign o_in_ready  = r_in_ready;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_cpu_hold  = r_cpu_hold;
    assign o_done      = r_done;
    assign o_err       = r_err;

    // Frame parser FSM with registered outputs; ready tracks the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_len       <= '0;
            r_len_lo    <= '0;
            r_xor       <= '0;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_hold  <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (i_start) begin
                        r_state    <= ST_LEN_LO;
                        r_cnt      <= '0;
                        r_xor      <= '0;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_cpu_hold <= 1'b1;
                        r_in_ready <= 1'b1;
                    end
                end
                ST_LEN_LO: begin
                    if (w_accept) begin
                        r_len_lo <= i_in_data;
                        r_state  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (w_accept) begin
                        if (w_len > LEN_W'(DEPTH)) begin
                            r_state    <= ST_ERR;
                            r_err      <= 1'b1;
                            r_in_ready <= 1'b0;
                        end else if (w_len == '0) begin
                            r_state <= ST_CHK;
                        end else begin
                            r_len   <= CW'(w_len);
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_cnt[AW-1:0];
                        r_mem_wdata <= i_in_data;
                        r_cnt       <= w_cnt_nxt;
                        r_xor       <= r_xor ^ i_in_data;
                        if (w_cnt_nxt == r_len) begin
                            r_state <= ST_CHK;
                        end
                    end
                end
                ST_CHK: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (i_in_data == r_xor) begin
                            r_state    <= ST_DONE;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed and random frames
// against a frame-level reference model.
module tb_imem_boot_loader;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned WIDTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       done;
    logic       err;

    imem_boot_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_cpu_hold  (cpu_hold),
        .o_done      (done),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    wr_t        exp_q[$];
    logic [7:0] dut_mem [DEPTH];
    bit         acc_at_edge;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must follow an accept and match the model.
    always @(posedge clk) begin
        wr_t e;
        acc_at_edge = in_valid && in_ready;
        #1;
        if (mem_we === 1'b1) begin
            chk("wr_after_accept", 32'(acc_at_edge), 32'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.a));
                chk("wr_data", 32'(mem_wdata), 32'(e.d));
            end
            dut_mem[mem_addr] = mem_wdata;
        end
    end

    // Hang guard.
    initial begin
        #500000;
        $error("FAIL global_timeout: observed hang expected finish");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("accept_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_we"},    32'(mem_we),   32'd0);
        chk({tag, "_addr"},  32'(mem_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_hold"},  32'(cpu_hold), 32'd1);
        chk({tag, "_done"},  32'(done),     32'd0);
        chk({tag, "_err"},   32'(err),      32'd0);
    endtask

    // Drive one framed image and check the outcome predicted from its bytes.
    task automatic run_frame(input string tag, input logic [7:0] fb[$], input int maxgap);
        int         len;
        int         nsend;
        int         bad;
        bit         ok_len;
        bit         exp_done;
        logic [7:0] x;
        len    = int'(fb[0]) + 256 * int'(fb[1]);
        ok_len = (len <= int'(DEPTH));
        x      = 8'h00;
        for (int i = 0; i < int'(DEPTH); i++) dut_mem[i] = 8'hxx;
        if (ok_len) begin
            for (int i = 0; i < len; i++) begin
                exp_q.push_back(wr_t'({8'(i), fb[2 + i]}));
                x = x ^ fb[2 + i];
            end
            exp_done = (x == fb[2 + len]);
            nsend    = len + 3;
        end else begin
            exp_done = 1'b0;
            nsend    = 2;
        end
        // start with a competing stream byte that must not be consumed
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        chk({tag, "_hold_armed"}, 32'(cpu_hold), 32'd1);
        for (int i = 0; i < nsend; i++) send_byte(fb[i], int'($urandom_range(maxgap, 0)));
        in_valid = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        chk({tag, "_err"},  32'(err),  32'(!exp_done));
        chk({tag, "_hold"}, 32'(cpu_hold), 32'(!exp_done));
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
        if (ok_len) begin
            bad = 0;
            for (int i = 0; i < len; i++) if (dut_mem[i] !== fb[2 + i]) bad++;
            chk({tag, "_image"}, 32'(bad), 32'd0);
        end
        // trailing bytes stay unconsumed
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (3) @(negedge clk);
        chk({tag, "_ready_after"}, 32'(in_ready), 32'd0);
        chk({tag, "_done_stable"}, 32'(done), 32'(exp_done));
        in_valid = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] f[$];
        logic [7:0] x;
        logic [7:0] p0;
        logic [7:0] p1;
        int         len;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        f = {8'h04, 8'h00, 8'h3C, 8'h08, 8'h00, 8'h01, 8'h35};
        run_frame("nominal", f, 0);

        f = {8'h04, 8'h00, 8'h3C, 8'h08, 8'h00, 8'h01, 8'h34};
        run_frame("cksum_err", f, 0);

        f = {8'h01, 8'h01};
        run_frame("oversize", f, 0);

        f = {8'h00, 8'h00, 8'h00};
        run_frame("zero_len", f, 0);

        f = {8'h00, 8'h01};
        for (int i = 0; i < 256; i++) f.push_back(8'(i));
        f.push_back(8'h00);
        run_frame("full_len", f, 0);

        // throttled random frames, some with a corrupted checksum
        for (int k = 0; k < 6; k++) begin
            len = int'($urandom_range(40, 1));
            f   = {8'(len), 8'h00};
            x   = 8'h00;
            for (int i = 0; i < len; i++) begin
                f.push_back(8'($urandom));
                x = x ^ f[2 + i];
            end
            if ($urandom_range(3, 0) == 0) x = x ^ 8'h01;
            f.push_back(x);
            run_frame("throttled", f, 3);
        end

        // reset after the second payload byte
        p0 = 8'($urandom);
        p1 = 8'($urandom);
        exp_q.push_back(wr_t'({8'd0, p0}));
        exp_q.push_back(wr_t'({8'd1, p1}));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        send_byte(p0, 0);
        send_byte(p1, 0);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        chk("mid_reset_writes_seen", 32'(exp_q.size()), 32'd0);
        rst = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h77;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("mid_reset_idle_ready", 32'(in_ready), 32'd0);

        len = 24;
        f   = {8'(len), 8'h00};
        x   = 8'h00;
        for (int i = 0; i < len; i++) begin
            f.push_back(8'($urandom));
            x = x ^ f[2 + i];
        end
        f.push_back(x);
        run_frame("after_reset", f, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
